// File: rtl/boot_rom_arbiter.sv
// boot_rom_arbiter
//
// Purpose:
//   Shares the single read port of boot_rom between the instruction-fetch
//   port and the load port. Each access runs IDLE -> READ -> DONE, so every
//   request is acknowledged exactly two cycles after it is granted. Ties are
//   broken round-robin. Addresses outside the ROM byte window complete
//   normally, but they return zero data and raise the error flag together
//   with the ack.
//
// Parameters:
//   ADDR_W     ROM word-address width (ROM holds 2^ADDR_W 32-bit words)
//   BASE_ADDR  byte base of the ROM window, aligned to 2^(ADDR_W+2)
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_inst_addr, i_inst_req       fetch request (level, held until ack)
//   o_inst_data/ack/err           fetch response (ack is a 1-cycle pulse)
//   i_ld_addr, i_ld_req           load request (level, held until ack)
//   o_ld_data/ack/err             load response (ack is a 1-cycle pulse)
//   o_rom_addr                    word address to boot_rom (sampled every edge)
//   i_rom_data                    boot_rom data, valid the cycle after sampling
//   o_busy                        high while in READ or DONE

module boot_rom_arbiter #(
    parameter int          ADDR_W    = 9,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [31:0]       i_inst_addr,
    input  logic              i_inst_req,
    output logic [31:0]       o_inst_data,
    output logic              o_inst_ack,
    output logic              o_inst_err,
    input  logic [31:0]       i_ld_addr,
    input  logic              i_ld_req,
    output logic [31:0]       o_ld_data,
    output logic              o_ld_ack,
    output logic              o_ld_err,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [31:0]       i_rom_data,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        PORT_INST = 1'b0,
        PORT_LD   = 1'b1
    } port_t;

    // Bits above the ROM window; these must equal BASE_ADDR for a hit.
    localparam logic [31:0] WIN_MASK = ~((32'd1 << (ADDR_W + 2)) - 32'd1);

    state_t      state, state_nxt;
    port_t       pointer, pointer_nxt;
    port_t       cur_port, cur_port_nxt;
    logic [31:0] cap_addr, cap_addr_nxt;

    logic        any_req;
    logic        pick_ld;
    logic [31:0] sel_addr;
    logic        in_window;

    // Request selection. The load port wins only when it is alone, or when
    // both ports are requesting and fetch was the most recent grant.
    always_comb begin
        any_req  = i_inst_req | i_ld_req;
        pick_ld  = i_ld_req & (~i_inst_req | (pointer == PORT_INST));
        sel_addr = pick_ld ? i_ld_addr : i_inst_addr;
    end

    // The window check uses the captured address, so it stays stable
    // through READ even though the requester's address is not registered.
    assign in_window = ((cap_addr & WIN_MASK) == BASE_ADDR);

    assign o_busy = (state != ST_IDLE);

    // Control state, round-robin pointer and the captured request. The
    // pointer resets to LD, so fetch wins the first tie after reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            pointer  <= PORT_LD;
            cur_port <= PORT_INST;
            cap_addr <= 32'd0;
        end else begin
            state    <= state_nxt;
            pointer  <= pointer_nxt;
            cur_port <= cur_port_nxt;
            cap_addr <= cap_addr_nxt;
        end
    end

    // Next-state logic and the ROM address. During a grant in IDLE, the ROM
    // address comes straight from the selected requester, so the ROM samples
    // it on the same edge that moves the FSM to READ. At all other times the
    // ROM address is taken from the captured address.
    always_comb begin
        state_nxt    = state;
        pointer_nxt  = pointer;
        cur_port_nxt = cur_port;
        cap_addr_nxt = cap_addr;
        o_rom_addr   = cap_addr[ADDR_W+1:2];

        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nxt    = ST_READ;
                    cur_port_nxt = pick_ld ? PORT_LD : PORT_INST;
                    pointer_nxt  = pick_ld ? PORT_LD : PORT_INST;
                    cap_addr_nxt = sel_addr;
                    o_rom_addr   = sel_addr[ADDR_W+1:2];
                end
            end
            ST_READ: state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Response registers. The ROM word is captured at the end of READ, so
    // data, ack and err all appear together in DONE. There is no
    // combinational path from i_rom_data to the outputs. Acks and errs fall
    // on the next edge. Data is held until that port's next completion.
    // A reset clears everything, which drops any access in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_inst_ack  <= 1'b0;
            o_inst_err  <= 1'b0;
            o_inst_data <= 32'd0;
            o_ld_ack    <= 1'b0;
            o_ld_err    <= 1'b0;
            o_ld_data   <= 32'd0;
        end else begin
            o_inst_ack <= 1'b0;
            o_inst_err <= 1'b0;
            o_ld_ack   <= 1'b0;
            o_ld_err   <= 1'b0;
            if (state == ST_READ) begin
                if (cur_port == PORT_INST) begin
                    o_inst_ack  <= 1'b1;
                    o_inst_err  <= ~in_window;
                    o_inst_data <= in_window ? i_rom_data : 32'd0;
                end else begin
                    o_ld_ack    <= 1'b1;
                    o_ld_err    <= ~in_window;
                    o_ld_data   <= in_window ? i_rom_data : 32'd0;
                end
            end
        end
    end

endmodule
